pipe_ctrl: RTL
==============

// Module: pipe_ctrl
// PURPOSE
//  Central pipeline sequencer for the 5-stage core. Arbitrates stall requests from ID/EX/MEM.
//  Drives the per-stage hold vector to pc_reg, if_id, id_ex, ex_mem and mem_wb.
//  Owns exception flush sequencing and the redirect PC. Runs a stall watchdog and a stall perf counter.
// PARAMETERS
//  FLUSH_CYCLES  2    cycles flush stays high after an accepted flush_req (>=1)
//  MAX_STALL     64   consecutive stall cycles before stall_timeout fires (>=2)
//  CNT_W         32   width of stall_cycles perf counter
// PORTS
//  clk            in   1      core clock; all state updates on posedge
//  rst            in   1      synchronous, active-high reset (`RstEnable)
//  stallreq_id    in   1      ID needs hold (load-use hazard)
//  stallreq_ex    in   1      EX needs hold (multi-cycle madd/msub/div)
//  stallreq_mem   in   1      MEM needs hold (bus wait)
//  flush_req      in   1      exception commit; single-cycle pulse
//  excp_pc        in   32     handler PC, valid with flush_req
//  stall          out  6      [0]pc [1]if [2]id [3]ex [4]mem [5]wb; 1 = hold stage
//  flush          out  1      clear all pipeline regs to NOP
//  new_pc         out  32     redirect target, valid while flush=1
//  stall_timeout  out  1      1-cycle pulse: stall persisted MAX_STALL cycles
//  stall_cycles   out  CNT_W  total cycles with stall!=0 (wraps)
// BEHAVIOUR
//  Reset (rst=1 at edge): state=RUN; stall=0, flush=0, new_pc=0, stall_timeout=0, stall_cycles=0.
//   Reset overrides any in-progress FLUSH or stall.
//  FSM states: RUN, STALL, FLUSH.
//  stall vector is combinational from the current-cycle requests; no added latency:
//   - stallreq_mem -> 6'b011111; else stallreq_ex -> 6'b001111; else stallreq_id -> 6'b000111; else 0.
//   - Forced to 0 when state=FLUSH or flush_req=1.
//  Transitions, priority flush_req > stall > none:
//   - Any state, flush_req=1: latch excp_pc into new_pc; load flush_cnt=FLUSH_CYCLES-1; go to FLUSH.
//   - RUN: any stallreq -> STALL.
//   - STALL: all stallreq low -> RUN.
//   - FLUSH: flush_cnt==0 -> RUN; otherwise decrement.
//   - Stall requests are ignored while in FLUSH.
//  flush=1 exactly while state=FLUSH: FLUSH_CYCLES cycles, starting the cycle after flush_req.
//   new_pc is held stable throughout and keeps its value after the flush.
//  flush_req during FLUSH restarts the count and reloads new_pc (last request wins).
//  Watchdog stall_run counter, width clog2(MAX_STALL+1):
//   - +1 each cycle stall!=0; cleared when stall==0; saturates at MAX_STALL.
//   - stall_timeout pulses for exactly one cycle, in the cycle after the counter reaches MAX_STALL.
//   - No re-fire until the counter has been cleared.
//  stall_cycles: +1 in each cycle where stall!=0 (registered); wraps modulo 2^CNT_W.
//  Simultaneous flush_req and stallreq: flush wins, stall=0 that cycle.
//  Requests are sampled only at clk; no combinational path from flush_req to flush.
// STRUCTURE
//  defines.sv additions:
//   - macros `StallIdMask (6'b000111), `StallExMask (6'b001111), `StallMemMask (6'b011111), `NoStall.
//   - macro `InstAddrBus reused for excp_pc and new_pc.
//  Package pipe_pkg: typedef enum logic[1:0] {RUN, STALL, FLUSH} pipe_state_t.
//  One sub-module stall_watchdog #(MAX_STALL):
//   - ports clk, rst, stall_active, timeout.
//   - contains the saturating run counter and the pulse logic.
//  Stall-vector mux and FSM stay in pipe_ctrl.
// TESTING
//  1. Reset -> all outputs 0; assert rst mid-FLUSH -> next cycle flush=0, state RUN, new_pc=0.
//  2. stallreq_id=1 for 3 cycles -> stall=6'b000111 same cycles; stall_cycles increments by 3.
//  3. stallreq_id=1 & stallreq_ex=1 -> 6'b001111; add stallreq_mem=1 -> 6'b011111.
//  4. flush_req pulse, excp_pc=32'h0000_0020, stallreq_ex=1 same cycle:
//     stall=0 that cycle; flush=1 for 2 cycles from next edge; new_pc=32'h20.
//  5. Second flush_req (excp_pc=32'h40) in flush cycle 1 -> flush extends 2 more cycles; new_pc=32'h40.
//  6. MAX_STALL=4, stallreq_mem held 6 cycles -> exactly one stall_timeout pulse, in cycle 5;
//     drop request 1 cycle, then re-raise -> pulse again after 4 more stall cycles.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline sequencer: FSM states and per-stage hold masks.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } pipe_state_t;

  localparam int INST_ADDR_W = 32;
  localparam int STALL_W     = 6;

  // Bit order of the hold vector: [0]pc [1]if [2]id [3]ex [4]mem [5]wb
  localparam logic [STALL_W-1:0] NO_STALL       = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_ID_MASK  = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX_MASK  = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_MEM_MASK = 6'b011111;

  // The deepest requester wins; its mask also holds every stage in front of it.
  function automatic logic [STALL_W-1:0] stall_mask(input logic req_id,
                                                    input logic req_ex,
                                                    input logic req_mem);
    logic [STALL_W-1:0] mask;
    mask = NO_STALL;
    if (req_mem)     mask = STALL_MEM_MASK;
    else if (req_ex) mask = STALL_EX_MASK;
    else if (req_id) mask = STALL_ID_MASK;
    return mask;
  endfunction

endpackage

// File: rtl/stall_watchdog.sv
// Counts consecutive stalled cycles and emits a one-cycle timeout pulse the cycle after
// the run reaches MAX_STALL; the counter saturates, so it only re-arms once stalling stops.
module stall_watchdog #(
  parameter int MAX_STALL = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_active,
  output logic timeout
);

  localparam int RUN_W = $clog2(MAX_STALL + 1);
  localparam logic [RUN_W-1:0] RUN_MAX    = RUN_W'(MAX_STALL);
  localparam logic [RUN_W-1:0] RUN_MAX_M1 = RUN_W'(MAX_STALL - 1);

  logic [RUN_W-1:0] r_run;
  logic             r_timeout;
  logic             w_hit;

  // True only on the single edge where the run count steps onto MAX_STALL.
  assign w_hit = stall_active && (r_run == RUN_MAX_M1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_run     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_hit;
      if (!stall_active) begin
        r_run <= '0;
      end else if (r_run != RUN_MAX) begin
        r_run <= r_run + 1'b1;
      end
    end
  end

  assign timeout = r_timeout;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall-vector arbitration, exception flush sequencing with redirect PC,
// stall watchdog and stalled-cycle perf counter.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int MAX_STALL    = 64,
  parameter int CNT_W        = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stallreq_id,
  input  logic                   stallreq_ex,
  input  logic                   stallreq_mem,
  input  logic                   flush_req,
  input  logic [INST_ADDR_W-1:0] excp_pc,
  output logic [STALL_W-1:0]     stall,
  output logic                   flush,
  output logic [INST_ADDR_W-1:0] new_pc,
  output logic                   stall_timeout,
  output logic [CNT_W-1:0]       stall_cycles
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FLUSH_LOAD = FC_W'(FLUSH_CYCLES - 1);

  pipe_state_t            r_state;
  pipe_state_t            w_state_nxt;
  logic [FC_W-1:0]        r_flush_cnt;
  logic [FC_W-1:0]        w_flush_cnt_nxt;
  logic [INST_ADDR_W-1:0] r_new_pc;
  logic [CNT_W-1:0]       r_stall_cycles;
  logic [STALL_W-1:0]     w_stall;
  logic                   w_any_req;
  logic                   w_stall_active;
  logic                   w_timeout;

  assign w_any_req = stallreq_id | stallreq_ex | stallreq_mem;

  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    w_stall         = NO_STALL;

    // Holding stages is pointless while they are being cleared, so a flush masks all stalls.
    if ((r_state != FLUSH) && !flush_req) begin
      w_stall = stall_mask(stallreq_id, stallreq_ex, stallreq_mem);
    end

    if (flush_req) begin
      w_state_nxt     = FLUSH;
      w_flush_cnt_nxt = FLUSH_LOAD;
    end else begin
      case (r_state)
        RUN: begin
          if (w_any_req) w_state_nxt = STALL;
        end
        STALL: begin
          if (!w_any_req) w_state_nxt = RUN;
        end
        FLUSH: begin
          if (r_flush_cnt == '0) begin
            w_state_nxt = RUN;
          end else begin
            w_flush_cnt_nxt = r_flush_cnt - 1'b1;
          end
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= RUN;
      r_flush_cnt    <= '0;
      r_new_pc       <= '0;
      r_stall_cycles <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      // Last request wins, including one arriving mid-flush; value persists after the flush.
      if (flush_req) r_new_pc <= excp_pc;
      if (w_stall_active) r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  assign w_stall_active = |w_stall;

  stall_watchdog #(
    .MAX_STALL (MAX_STALL)
  ) u_stall_watchdog (
    .clk          (clk),
    .rst          (rst),
    .stall_active (w_stall_active),
    .timeout      (w_timeout)
  );

  // flush comes straight from state, so flush_req never reaches it combinationally.
  assign flush         = (r_state == FLUSH);
  assign stall         = w_stall;
  assign new_pc        = r_new_pc;
  assign stall_timeout = w_timeout;
  assign stall_cycles  = r_stall_cycles;

endmodule
